// File: rtl/ncu_sii_ingress.sv
// SII->NCU inbound receiver: credit-based grant, 4-beat capture with halfword parity,
// and a valid/ready packet FIFO toward the NCU core.
module ncu_sii_ingress #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned REQ_CNT_W  = 3
) (
   input  logic         iol2clk,
   input  logic         rst_l,
   input  logic         sii_ncu_req,
   input  logic [31:0]  sii_ncu_data,
   input  logic [1:0]   sii_ncu_dparity,
   output logic         ncu_sii_gnt,
   output logic         pkt_vld,
   input  logic         pkt_rdy,
   output logic [127:0] pkt_data,
   output logic [2:0]   pkt_typ,
   output logic [3:0]   pkt_tag,
   output logic [8:0]   pkt_id,
   output logic         pkt_perr,
   output logic [7:0]   perr_cnt,
   output logic         req_ovf
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [REQ_CNT_W-1:0] PEND_MAX = '1;

   typedef enum logic [2:0] {IDLE, GNT, B0, B1, B2, B3} state_t;

   state_t                 state;
   logic [REQ_CNT_W-1:0]   pend;
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       count;
   logic [127:0]           mem_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]  mem_perr;
   logic [95:0]            asm_data;
   logic                   asm_perr;

   logic beat_err;
   logic inflight;
   logic space_ok;
   logic wr_en;
   logic full;
   logic push;
   logic pop;
   logic pkt_err;

   assign beat_err = (^sii_ncu_data[31:16] != sii_ncu_dparity[1]) |
                     (^sii_ncu_data[15:0]  != sii_ncu_dparity[0]);
   // Credit uses registered occupancy only; a same-cycle pop is not counted.
   assign inflight = (state != IDLE);
   assign space_ok = (SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);
   assign wr_en    = (state == B3);
   assign full     = (count == CNT_W'(FIFO_DEPTH));
   assign push     = wr_en && !full;
   assign pop      = pkt_vld && pkt_rdy;
   assign pkt_err  = asm_perr | beat_err;

   // Grant/beat sequencer; the grant flop mirrors entry into GNT.
   always_ff @(posedge iol2clk) begin
      if (!rst_l) begin
         state       <= IDLE;
         ncu_sii_gnt <= 1'b0;
      end else begin
         ncu_sii_gnt <= 1'b0;
         case (state)
            IDLE: begin
               if (((pend != '0) || sii_ncu_req) && space_ok) begin
                  state       <= GNT;
                  ncu_sii_gnt <= 1'b1;
               end
            end
            GNT:  state <= B0;
            B0:   state <= B1;
            B1:   state <= B2;
            B2:   state <= B3;
            B3: begin
               if ((pend != '0) && space_ok) begin
                  state       <= GNT;
                  ncu_sii_gnt <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outstanding request counter; a request at max is dropped and flagged.
   always_ff @(posedge iol2clk) begin
      if (!rst_l) begin
         pend    <= '0;
         req_ovf <= 1'b0;
      end else begin
         case ({sii_ncu_req, ncu_sii_gnt})
            2'b10: begin
               if (pend == PEND_MAX) req_ovf <= 1'b1;
               else                  pend    <= pend + REQ_CNT_W'(1);
            end
            2'b01:   pend <= pend - REQ_CNT_W'(1);
            default: pend <= pend;
         endcase
      end
   end

   // Beat assembly; beat3 goes straight into the FIFO write.
   always_ff @(posedge iol2clk) begin
      if (!rst_l) begin
         asm_data <= '0;
         asm_perr <= 1'b0;
      end else begin
         case (state)
            B0: begin
               asm_data[31:0] <= sii_ncu_data;
               asm_perr       <= beat_err;
            end
            B1: begin
               asm_data[63:32] <= sii_ncu_data;
               asm_perr        <= asm_perr | beat_err;
            end
            B2: begin
               asm_data[95:64] <= sii_ncu_data;
               asm_perr        <= asm_perr | beat_err;
            end
            default: ;
         endcase
      end
   end

   // Packet FIFO storage and pointers.
   always_ff @(posedge iol2clk) begin
      if (!rst_l) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_data[i] <= '0;
         mem_perr <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= {sii_ncu_data, asm_data};
            mem_perr[wr_ptr] <= pkt_err;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge iol2clk) begin
      if (!rst_l) begin
         perr_cnt <= '0;
      end else if (push && pkt_err && (perr_cnt != 8'hFF)) begin
         perr_cnt <= perr_cnt + 8'(1);
      end
   end

   assign pkt_vld  = (count != '0);
   assign pkt_data = mem_data[rd_ptr];
   assign pkt_perr = mem_perr[rd_ptr];
   assign pkt_typ  = pkt_data[15:13];
   assign pkt_tag  = pkt_data[12:9];
   assign pkt_id   = pkt_data[8:0];

   a_no_write_when_full: assert property (@(posedge iol2clk) disable iff (!rst_l) !(wr_en && full));

endmodule

// File: tb/tb_ncu_sii_ingress.sv
// Directed bench for ncu_sii_ingress: single packet, parity error, reset abort,
// back-to-back, full backpressure and request overflow.
module tb_ncu_sii_ingress;

   logic         iol2clk = 1'b0;
   logic         rst_l = 1'b0;
   logic         sii_ncu_req = 1'b0;
   logic [31:0]  sii_ncu_data = '0;
   logic [1:0]   sii_ncu_dparity = '0;
   logic         pkt_rdy = 1'b0;
   logic         ncu_sii_gnt;
   logic         pkt_vld;
   logic [127:0] pkt_data;
   logic [2:0]   pkt_typ;
   logic [3:0]   pkt_tag;
   logic [8:0]   pkt_id;
   logic         pkt_perr;
   logic [7:0]   perr_cnt;
   logic         req_ovf;

   typedef struct packed {
      logic [3:0][31:0] d;
      logic [3:0][1:0]  p;
   } pkt_t;

   int     n_chk = 0;
   int     n_err = 0;
   pkt_t   tx_q[$];
   logic [127:0] rx_q[$];

   ncu_sii_ingress #(.FIFO_DEPTH(4), .REQ_CNT_W(3)) dut (
      .iol2clk(iol2clk), .rst_l(rst_l),
      .sii_ncu_req(sii_ncu_req), .sii_ncu_data(sii_ncu_data), .sii_ncu_dparity(sii_ncu_dparity),
      .ncu_sii_gnt(ncu_sii_gnt), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .pkt_data(pkt_data),
      .pkt_typ(pkt_typ), .pkt_tag(pkt_tag), .pkt_id(pkt_id), .pkt_perr(pkt_perr),
      .perr_cnt(perr_cnt), .req_ovf(req_ovf)
   );

   always #5 iol2clk = ~iol2clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge iol2clk);
      #1;
   endtask

   function automatic pkt_t mk_pkt(input logic [31:0] b0, input logic [31:0] b1,
                                    input logic [31:0] b2, input logic [31:0] b3);
      pkt_t pk;
      pk.d[0] = b0; pk.d[1] = b1; pk.d[2] = b2; pk.d[3] = b3;
      for (int i = 0; i < 4; i++) pk.p[i] = {^pk.d[i][31:16], ^pk.d[i][15:0]};
      return pk;
   endfunction

   function automatic pkt_t mk_seq(input int k);
      logic [31:0] base;
      base = 32'hA000_0000 + 32'(k) * 32'h0101_0101;
      return mk_pkt(base, base + 32'h10, base + 32'h200, base + 32'h3000);
   endfunction

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_gnt"},  128'(ncu_sii_gnt), 128'(1'b0));
      check({pfx, "_vld"},  128'(pkt_vld),     128'(1'b0));
      check({pfx, "_data"}, pkt_data,          128'(0));
      check({pfx, "_typ"},  128'(pkt_typ),     128'(0));
      check({pfx, "_tag"},  128'(pkt_tag),     128'(0));
      check({pfx, "_id"},   128'(pkt_id),      128'(0));
      check({pfx, "_perr"}, 128'(pkt_perr),    128'(0));
      check({pfx, "_pcnt"}, 128'(perr_cnt),    128'(0));
      check({pfx, "_ovf"},  128'(req_ovf),     128'(0));
   endtask

   // SII side: four beats in the cycles after each grant, junk with bad parity otherwise.
   initial begin : sii_drv
      pkt_t cur;
      int   bk;
      cur = '0;
      bk  = -1;
      forever begin
         @(posedge iol2clk);
         #1;
         if (bk >= 0) begin
            sii_ncu_data    = cur.d[2'(bk)];
            sii_ncu_dparity = cur.p[2'(bk)];
            bk = (bk == 3) ? -1 : bk + 1;
         end else begin
            sii_ncu_data    = 32'hFFFF_0000;
            sii_ncu_dparity = 2'b01;
         end
         if (ncu_sii_gnt) begin
            if (tx_q.size() > 0) cur = tx_q.pop_front();
            else                 cur = '0;
            bk = 0;
         end
      end
   end

   // Delivered-packet monitor.
   always @(negedge iol2clk) begin
      if (rst_l && pkt_vld && pkt_rdy) rx_q.push_back(pkt_data);
   end

   initial begin : main
      pkt_t p1, p2, p3;
      pkt_t seq[$];
      int   gcnt;

      // reset
      rst_l = 1'b0;
      tick(3);
      rst_l = 1'b1;
      check_reset_outputs("rst");
      tick(5);

      // single packet
      p1 = mk_pkt(32'h0000_A5FF, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666);
      tx_q.push_back(p1);
      sii_ncu_req = 1'b1;
      tick(1);
      sii_ncu_req = 1'b0;
      check("t1_gnt_r1", 128'(ncu_sii_gnt), 128'(1'b1));
      tick(1);
      check("t1_gnt_r2", 128'(ncu_sii_gnt), 128'(1'b0));
      tick(3);
      check("t1_vld_r5", 128'(pkt_vld), 128'(1'b0));
      tick(1);
      check("t1_vld_r6", 128'(pkt_vld),  128'(1'b1));
      check("t1_data",   pkt_data,       128'(p1.d));
      check("t1_typ",    128'(pkt_typ),  128'(3'd5));
      check("t1_tag",    128'(pkt_tag),  128'(4'd2));
      check("t1_id",     128'(pkt_id),   128'(9'h1FF));
      check("t1_perr",   128'(pkt_perr), 128'(1'b0));
      check("t1_pcnt",   128'(perr_cnt), 128'(8'd0));
      pkt_rdy = 1'b1;
      tick(1);
      pkt_rdy = 1'b0;
      check("t1_vld_pop", 128'(pkt_vld), 128'(1'b0));

      // parity error on beat2 upper half; header from beat0 only
      p2 = mk_pkt(32'hCAFE_3E15, 32'h0BAD_F00D, 32'h1357_9BDF, 32'h2468_ACE0);
      p2.p[2][1] = ~p2.p[2][1];
      tx_q.push_back(p2);
      sii_ncu_req = 1'b1;
      tick(1);
      sii_ncu_req = 1'b0;
      tick(5);
      check("t2_vld",  128'(pkt_vld),  128'(1'b1));
      check("t2_perr", 128'(pkt_perr), 128'(1'b1));
      check("t2_pcnt", 128'(perr_cnt), 128'(8'd1));
      check("t2_data", pkt_data,       128'(p2.d));
      check("t2_typ",  128'(pkt_typ),  128'(3'd1));
      check("t2_tag",  128'(pkt_tag),  128'(4'hF));
      check("t2_id",   128'(pkt_id),   128'(9'h015));
      pkt_rdy = 1'b1;
      tick(1);
      pkt_rdy = 1'b0;

      // reset while in B1
      p3 = mk_pkt(32'h0000_1234, 32'h5, 32'h6, 32'h7);
      tx_q.push_back(p3);
      sii_ncu_req = 1'b1;
      tick(1);
      sii_ncu_req = 1'b0;
      tick(2);
      rst_l = 1'b0;
      tick(1);
      rst_l = 1'b1;
      check_reset_outputs("t6");
      gcnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (ncu_sii_gnt) gcnt++;
         tick(1);
      end
      check("t6_no_gnt", 128'(gcnt),     128'(0));
      check("t6_vld",    128'(pkt_vld),  128'(1'b0));
      check("t6_pend",   128'(dut.pend), 128'(0));

      // back-to-back: three requests in consecutive cycles
      rx_q.delete();
      tx_q.delete();
      seq.delete();
      for (int k = 1; k <= 3; k++) begin
         seq.push_back(mk_seq(k));
         tx_q.push_back(mk_seq(k));
      end
      pkt_rdy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) check($sformatf("t3_gnt_%0d", i), 128'(ncu_sii_gnt),
                          128'((i == 1) || (i == 6) || (i == 11)));
         sii_ncu_req = (i < 3);
         tick(1);
      end
      tick(3);
      check("t3_rx_n", 128'(rx_q.size()), 128'(3));
      for (int k = 0; k < 3 && k < rx_q.size(); k++)
         check($sformatf("t3_rx_%0d", k), rx_q[k], 128'(seq[k].d));
      check("t3_pend", 128'(dut.pend), 128'(0));
      pkt_rdy = 1'b0;

      // full backpressure: six requests, four fit
      rx_q.delete();
      seq.delete();
      for (int k = 10; k < 16; k++) begin
         seq.push_back(mk_seq(k));
         tx_q.push_back(mk_seq(k));
      end
      for (int i = 0; i < 31; i++) begin
         if (i > 0) check($sformatf("t4_gnt_%0d", i), 128'(ncu_sii_gnt),
                          128'((i == 1) || (i == 6) || (i == 11) || (i == 16)));
         sii_ncu_req = (i < 6);
         tick(1);
      end
      check("t4_vld",  128'(pkt_vld),  128'(1'b1));
      check("t4_head", pkt_data,       128'(seq[0].d));
      check("t4_pend", 128'(dut.pend), 128'(2));
      pkt_rdy = 1'b1;
      tick(1);
      pkt_rdy = 1'b0;
      check("t4_gnt_p1", 128'(ncu_sii_gnt), 128'(1'b0));
      tick(1);
      check("t4_gnt_p2", 128'(ncu_sii_gnt), 128'(1'b1));
      tick(1);
      check("t4_gnt_p3", 128'(ncu_sii_gnt), 128'(1'b0));
      pkt_rdy = 1'b1;
      tick(40);
      check("t4_rx_n", 128'(rx_q.size()), 128'(6));
      for (int k = 0; k < 6 && k < rx_q.size(); k++)
         check($sformatf("t4_rx_%0d", k), rx_q[k], 128'(seq[k].d));
      check("t4_pend_end", 128'(dut.pend), 128'(0));
      check("t4_vld_end",  128'(pkt_vld),  128'(1'b0));
      pkt_rdy = 1'b0;

      // overflow: fill FIFO, then eight requests with no space
      for (int k = 20; k < 24; k++) tx_q.push_back(mk_seq(k));
      for (int i = 0; i < 4; i++) begin
         sii_ncu_req = 1'b1;
         tick(1);
      end
      sii_ncu_req = 1'b0;
      tick(30);
      check("t5_full_vld", 128'(pkt_vld),  128'(1'b1));
      check("t5_pend0",    128'(dut.pend), 128'(0));
      for (int i = 0; i < 7; i++) begin
         sii_ncu_req = 1'b1;
         tick(1);
      end
      sii_ncu_req = 1'b0;
      tick(1);
      check("t5_pend7", 128'(dut.pend), 128'(7));
      check("t5_ovf0",  128'(req_ovf),  128'(1'b0));
      sii_ncu_req = 1'b1;
      tick(1);
      sii_ncu_req = 1'b0;
      check("t5_ovf1",     128'(req_ovf),     128'(1'b1));
      check("t5_pend_hold",128'(dut.pend),    128'(7));
      tick(10);
      check("t5_ovf_stky", 128'(req_ovf),     128'(1'b1));
      check("t5_no_gnt",   128'(ncu_sii_gnt), 128'(1'b0));

      // reset clears sticky flag, pointers and pending count
      rst_l = 1'b0;
      tick(1);
      rst_l = 1'b1;
      check_reset_outputs("fin");
      check("fin_pend", 128'(dut.pend), 128'(0));
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ncu_sii_ingress.md
# ncu_sii_ingress

NCU-side receiver for the SII→NCU inbound path (Mondo interrupts and PIO read completions). It counts SII request pulses and issues `ncu_sii_gnt` only when buffer space is guaranteed. After each grant it captures the four 32-bit payload beats and checks per-halfword parity. It then presents each packet, with its decoded header, to the downstream NCU logic through a valid/ready FIFO.

## Interface
- `FIFO_DEPTH`, 4: packet buffer entries (power of two, 2..16).
- `REQ_CNT_W`, 3: width of the pending-request counter.

- `iol2clk`  in  1  clock; all logic on rising edge.
- `rst_l`  in  1  reset; one clock; reset is synchronous and active-low.
- `sii_ncu_req`  in  1  one-cycle pulse per packet SII wants to send.
- `sii_ncu_data`  in  32  payload beat.
- `sii_ncu_dparity`  in  2  bit1 = even parity of data[31:16], bit0 = even parity of data[15:0].
- `ncu_sii_gnt`  out  1  one-cycle grant, registered.
- `pkt_vld`  out  1  FIFO head valid.
- `pkt_rdy`  in  1  downstream accepts head when `pkt_vld && pkt_rdy`.
- `pkt_data`  out  128  beat0 in [31:0] … beat3 in [127:96].
- `pkt_typ`  out  3  beat0 data[15:13].
- `pkt_tag`  out  4  beat0 data[12:9].
- `pkt_id`  out  9  beat0 data[8:0].
- `pkt_perr`  out  1  any beat of this packet failed parity.
- `perr_cnt`  out  8  packets with parity error; saturates at 255.
- `req_ovf`  out  1  sticky; a request arrived with the pending counter at max.

## Operation
- **Pending counter `pend`**
  - +1 on `sii_ncu_req`; −1 on each `ncu_sii_gnt`.
  - Req and gnt in the same cycle leave `pend` unchanged.
  - At max value (2^REQ_CNT_W−1), a req with no gnt holds `pend`, sets `req_ovf`, and the request is lost.
- **Credit**
  - `space = FIFO_DEPTH − occupancy − inflight`; `inflight` is 1 from gnt through the beat3 write.
  - A pop in the current cycle does not count toward `space`: use registered occupancy.
- **FSM states:** IDLE, GNT, B0, B1, B2, B3.
  - IDLE → GNT when `pend > 0` (or a req this cycle) and `space > 0`. Drive `ncu_sii_gnt` = 1 from the registered GNT state.
  - GNT → B0 → B1 → B2 → B3, unconditionally, one cycle each. Beat k is sampled in state Bk.
  - B3 writes the assembled packet into the FIFO.
  - From B3, go to GNT if `pend > 0` and `space > 0` (back-to-back), else IDLE.
- **Parity**
  - Each beat computes `^data[31:16] != dparity[1]` or `^data[15:0] != dparity[0]`.
  - Errors OR-accumulate across the 4 beats into `pkt_perr`.
  - The packet is still enqueued.
  - `perr_cnt` increments at the B3 write when the accumulated error is 1.
- **Header:** `pkt_typ`, `pkt_tag` and `pkt_id` are stored from beat0 only; beats 1–3 do not alter them.
- **FIFO**
  - Circular buffer; write pointer and read pointer wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle keep occupancy unchanged.
  - Pop with `pkt_vld` = 0 is ignored.
  - Overflow is impossible by credit rule. If a write occurs while full, the assertion fires; in RTL the write is dropped.
- **Reset:** the state machine returns to IDLE, any partial packet is discarded, and `pend`, FIFO pointers, `perr_cnt` and `req_ovf` are cleared. A grant already issued is not replayed.

## Timing
- **Reset values:** `ncu_sii_gnt`=0, `pkt_vld`=0, `pkt_data`/`pkt_typ`/`pkt_tag`/`pkt_id`/`pkt_perr`=0, `perr_cnt`=0, `req_ovf`=0.
- **Minimum latency:** req in cycle R (IDLE, space available), gnt in R+1, beats sampled in R+2..R+5, `pkt_vld` high in R+6.
- **Back-to-back:** next gnt is asserted in the cycle after B3, so gnt spacing is at least 5 cycles. Beats of consecutive packets occupy contiguous 4-cycle windows separated by a one-cycle grant.
- `sii_ncu_data` is ignored outside the B0–B3 states.
- The FIFO head is stable while `pkt_vld && !pkt_rdy`.
- **Empty:** `pkt_vld` falls in the cycle after the last pop.
- **Full:** no gnt is issued until a pop frees an entry. The gnt is issued at the earliest one cycle after the pop.

## Test plan
- **Single packet:** req at cycle 10; beats 0x0000_A5FF, 0x1111_2222, 0x3333_4444, 0x5555_6666 with correct parity.
  - gnt at 11; `pkt_vld` at 16.
  - `pkt_typ`=5, `pkt_tag`=2, `pkt_id`=0x1FF, `pkt_perr`=0.
- **Parity error:** flip `dparity[1]` on beat2 → `pkt_perr`=1, `perr_cnt`=1, packet data intact.
- **Back-to-back:** 3 req pulses in consecutive cycles, `pkt_rdy`=1 → gnts spaced exactly 5 cycles apart, 3 packets delivered in order, `pend` returns to 0.
- **Full backpressure:** `FIFO_DEPTH`=4, `pkt_rdy`=0, 6 reqs.
  - Exactly 4 gnts, then gnt stays low.
  - Raise `pkt_rdy` for one cycle → one pop, and the 5th gnt follows one cycle later.
- **Overflow:** 8 reqs with no space (`REQ_CNT_W`=3) → `pend` holds 7, `req_ovf`=1 and stays 1.
- **Reset mid-transfer:** assert `rst_l`=0 in state B1 → all outputs at reset values next cycle. The FIFO stays empty and the partial packet is never delivered.
